// File: rtl/lsu_apb_master.sv
// lsu_apb_master: LSU data-memory APB initiator resolving byte offsets locally (shift/extend loads, RMW stores); LSU_APB_PREADY_EN enables pready_i wait states
module lsu_apb_master #(
  parameter int DMEM_ADDR = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_addr_i,
  input  logic                 req_we_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [DMEM_ADDR-1:0] paddr_o,
  output logic [31:0]          pwdata_o,
  output logic [2:0]           pfunct_code_o,
  input  logic [31:0]          prdata_i,
  input  logic                 pready_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [1:0] off;
  logic we;
  logic [2:0] f3;
  logic [15:0] wdata;
  logic rmw_wr;
  logic done;
  logic unused_ok;
  logic illegal;
  logic misaligned;
  logic [4:0] sh;
  logic [31:0] shifted;
  logic [31:0] ld_data;
  logic [31:0] mask;
  logic [31:0] merged;
`ifdef LSU_APB_PREADY_EN
  assign done = pready_i;
  assign unused_ok = ^req_addr_i[31:DMEM_ADDR+2];
`else
  assign done = 1'b1;
  assign unused_ok = ^{req_addr_i[31:DMEM_ADDR+2], pready_i};
`endif
  assign illegal = req_we_i ? (req_funct3_i[2] || req_funct3_i[1:0] == 2'b11)
                            : (req_funct3_i[1:0] == 2'b11 || req_funct3_i[2:1] == 2'b11);
  assign misaligned = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0])
                   || (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
  always_comb begin
    sh = {off, 3'b000};
    shifted = prdata_i >> sh;
    ld_data = f3[1:0] == 2'b10 ? shifted
            : f3[0] ? {{16{shifted[15] & ~f3[2]}}, shifted[15:0]}
            : {{24{shifted[7] & ~f3[2]}}, shifted[7:0]};
    mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    merged = (prdata_i & ~mask) | (({16'h0000, wdata}) << sh & mask);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
      psel_o <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o <= 1'b0;
      paddr_o <= '0;
      pwdata_o <= '0;
      pfunct_code_o <= '0;
      off <= '0;
      we <= 1'b0;
      f3 <= '0;
      wdata <= '0;
      rmw_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          off <= req_addr_i[1:0];
          we <= req_we_i;
          f3 <= req_funct3_i;
          wdata <= req_wdata_i[15:0];
          rmw_wr <= 1'b0;
          req_ready_o <= 1'b0;
          if (illegal || misaligned) begin
            state <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o <= 1'b1;
            rsp_rdata_o <= '0;
          end else begin
            state <= SETUP;
            psel_o <= 1'b1;
            paddr_o <= req_addr_i[DMEM_ADDR+1:2];
            pwrite_o <= req_we_i && req_addr_i[1:0] == 2'b00;
            pwdata_o <= req_wdata_i;
            pfunct_code_o <= req_addr_i[1:0] == 2'b00 ? req_funct3_i : 3'b010;
          end
        end
        SETUP: begin
          state <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: if (done) begin
          penable_o <= 1'b0;
          if (we && off != 2'b00 && !rmw_wr) begin
            state <= SETUP;
            rmw_wr <= 1'b1;
            pwrite_o <= 1'b1;
            pwdata_o <= merged;
          end else begin
            state <= RESP;
            psel_o <= 1'b0;
            pwrite_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o <= 1'b0;
            rsp_rdata_o <= we ? 32'h0 : off == 2'b00 ? prdata_i : ld_data;
          end
        end
        default: begin
          state <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_err_o <= 1'b0;
          rsp_rdata_o <= '0;
          req_ready_o <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_apb_master.sv
// tb_lsu_apb_master: directed checks of lsu_apb_master against a word-addressed lane-0 bank model
module tb_lsu_apb_master;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic req_we_i = 1'b0;
  logic [2:0] req_funct3_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic rsp_err_o;
  logic psel_o;
  logic penable_o;
  logic pwrite_o;
  logic [8:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [2:0] pfunct_code_o;
  logic [31:0] prdata_i;
  logic pready_i = 1'b1;
  logic [31:0] mem [0:511];
  int n_chk = 0;
  int n_fail = 0;
  int hold = 0;
  int lat, n_pen, n_sel;
  logic [8:0] su_addr;
  logic su_wr, got_setup, addr_moved, r_err, post_valid, post_ready, saw_valid;
  logic [2:0] su_code;
  logic [31:0] wr_data, r_data;

  lsu_apb_master #(.DMEM_ADDR(9)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_we_i(req_we_i), .req_funct3_i(req_funct3_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pfunct_code_o(pfunct_code_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] bank_rd(input logic [31:0] w, input logic [2:0] c);
    case (c)
      3'b000: bank_rd = {{24{w[7]}}, w[7:0]};
      3'b001: bank_rd = {{16{w[15]}}, w[15:0]};
      3'b100: bank_rd = {24'h0, w[7:0]};
      3'b101: bank_rd = {16'h0, w[15:0]};
      default: bank_rd = w;
    endcase
  endfunction

  function automatic logic [31:0] bank_wr(input logic [31:0] w, input logic [31:0] d, input logic [2:0] c);
    case (c)
      3'b000: bank_wr = {w[31:8], d[7:0]};
      3'b001: bank_wr = {w[31:16], d[15:0]};
      default: bank_wr = d;
    endcase
  endfunction

  assign prdata_i = (psel_o && penable_o && !pwrite_o) ? bank_rd(mem[paddr_o], pfunct_code_o) : 'z;

  always @(posedge clk_i)
    if (psel_o && penable_o && pwrite_o && pready_i)
      mem[paddr_o] <= bank_wr(mem[paddr_o], pwdata_o, pfunct_code_o);

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    pready_i = (hold == 0);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_funct3_i = f3;
    req_addr_i = addr;
    req_wdata_i = wd;
    tick();
    req_valid_i = 1'b0;
    lat = 1;
    n_pen = 0;
    n_sel = 0;
    got_setup = 1'b0;
    addr_moved = 1'b0;
    wr_data = 'x;
    while (!rsp_valid_o && lat < 20) begin
      if (psel_o && !penable_o && !got_setup) begin
        su_addr = paddr_o;
        su_wr = pwrite_o;
        su_code = pfunct_code_o;
        got_setup = 1'b1;
      end
      if (psel_o) n_sel++;
      if (penable_o) begin
        n_pen++;
        if (paddr_o !== su_addr) addr_moved = 1'b1;
        if (pwrite_o) wr_data = pwdata_o;
        pready_i = (n_pen > hold);
      end
      tick();
      lat++;
    end
    r_data = rsp_rdata_o;
    r_err = rsp_err_o;
    pready_i = 1'b1;
    tick();
    post_valid = rsp_valid_o;
    post_ready = req_ready_o;
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_code", pfunct_code_o, 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw_paddr", su_addr, 4);
    check("sw_pwrite", su_wr, 1);
    check("sw_code", su_code, 3'b010);
    check("sw_lat", lat, 3);
    check("sw_err", r_err, 0);
    check("sw_npen", n_pen, 1);
    check("sw_pwdata", wr_data, 32'hDEADBEEF);
    check("sw_pulse", post_valid, 0);
    check("sw_ready", post_ready, 1);

    run_req(1'b0, 3'b000, 32'h13, 32'h0);
    check("lb13_code", su_code, 3'b010);
    check("lb13_pwrite", su_wr, 0);
    check("lb13_npen", n_pen, 1);
    check("lb13_lat", lat, 3);
    check("lb13_rdata", r_data, 32'hFFFFFFDE);
    run_req(1'b0, 3'b100, 32'h13, 32'h0);
    check("lbu13_rdata", r_data, 32'h000000DE);
    run_req(1'b0, 3'b001, 32'h10, 32'h0);
    check("lh10_code", su_code, 3'b001);
    check("lh10_rdata", r_data, 32'hFFFFBEEF);
    run_req(1'b0, 3'b101, 32'h12, 32'h0);
    check("lhu12_rdata", r_data, 32'h0000DEAD);
    run_req(1'b0, 3'b000, 32'h11, 32'h0);
    check("lb11_rdata", r_data, 32'hFFFFFFBE);

    run_req(1'b1, 3'b000, 32'h11, 32'h000000AA);
    check("sb11_npen", n_pen, 2);
    check("sb11_pwdata", wr_data, 32'hDEADAAEF);
    check("sb11_lat", lat, 5);
    check("sb11_rdata", r_data, 0);
    check("sb11_code", su_code, 3'b010);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_after_sb", r_data, 32'hDEADAAEF);
    run_req(1'b1, 3'b001, 32'h12, 32'hFFFF1234);
    check("sh12_pwdata", wr_data, 32'h1234AAEF);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_after_sh", r_data, 32'h1234AAEF);

    run_req(1'b0, 3'b010, 32'h12, 32'h0);
    check("lw12_err", r_err, 1);
    check("lw12_lat", lat, 1);
    check("lw12_rdata", r_data, 0);
    check("lw12_nsel", n_sel, 0);
    run_req(1'b1, 3'b001, 32'h13, 32'h5555);
    check("sh13_err", r_err, 1);
    check("sh13_nsel", n_sel, 0);
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    check("ld011_err", r_err, 1);
    check("ld011_lat", lat, 1);
    run_req(1'b1, 3'b100, 32'h10, 32'h0);
    check("st100_err", r_err, 1);
    check("err_ready", post_ready, 1);

    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    req_funct3_i = 3'b000;
    req_addr_i = 32'h11;
    req_wdata_i = 32'h55;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    tick();
    check("rmw_wr_access", {penable_o, pwrite_o}, 2'b11);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_psel", psel_o, 0);
    check("rst_mid_penable", penable_o, 0);
    saw_valid = rsp_valid_o;
    tick();
    saw_valid = saw_valid | rsp_valid_o;
    tick();
    rst_ni = 1'b1;
    tick();
    saw_valid = saw_valid | rsp_valid_o;
    check("rst_mid_no_rsp", saw_valid, 0);
    check("rst_mid_ready", req_ready_o, 1);
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("rst_mid_word", r_data, 32'hDEADBEEF);

`ifdef LSU_APB_PREADY_EN
    hold = 3;
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    hold = 0;
    check("wait_npen", n_pen, 4);
    check("wait_lat", lat, 6);
    check("wait_addr_stable", addr_moved, 0);
    check("wait_rdata", r_data, 32'hDEADBEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
